video_pattern_gen: RTL and testbench
====================================

# video_pattern_gen

Video source block that drives the transmitter side of the display link (the `video_if` master fields CLK/HS/VS/BLANK/RGB) into the `screen` model or the HDMI encoder.
- Generates programmable raster timing (sync, blanking, active area).
- Fills the active area with a built-in test pattern or with pixels pulled from an upstream ready/valid stream.
- Lets the `Top` datapath be brought up and checked against `screen` before the framebuffer reader exists. Later, it becomes the framebuffer reader's pixel sink.

## Interface
Parameters:
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- HFP / HPULSE / HBP, 40 / 48 / 40, horizontal front porch, sync, back porch (pixels)
- VFP / VPULSE / VBP, 13 / 3 / 29, vertical front porch, sync, back porch (lines)
- GRID, 16, grid pitch in pixels (power of two)
- UNDERFLOW_RGB, 24'hFF00FF, colour emitted when the stream starves

Ports:
- pixel_clk  in  1  pixel clock
- pixel_rst_n  in  1  reset, asynchronous, active-low
- mode  in  2  pattern select (see package)
- pix_data  in  24  upstream pixel {R,G,B}
- pix_valid  in  1  upstream pixel valid
- pix_ready  out  1  block consumes pix_data this cycle
- frame_start  out  1  one-cycle pulse at raster origin
- underflow  out  1  sticky stream-starvation flag
- video_clk  out  1  forwarded pixel_clk (→ video_if.CLK)
- video_hs  out  1  horizontal sync, active-low (→ HS)
- video_vs  out  1  vertical sync, active-low (→ VS)
- video_blank  out  1  high in active area, i.e. data enable (→ BLANK)
- video_rgb  out  24  pixel colour (→ RGB)

## Operation
- Raster counters:
  - HTOTAL = HFP+HPULSE+HBP+HDISP and VTOTAL = VFP+VPULSE+VBP+VDISP.
  - hcnt runs 0..HTOTAL-1. vcnt advances when hcnt wraps and itself wraps at VTOTAL-1.
  - Region order on both axes: front porch, sync, back porch, active. The active area is hcnt ≥ HTOTAL-HDISP and vcnt ≥ VTOTAL-VDISP.
  - Active coordinates are x = hcnt-(HTOTAL-HDISP) and y = vcnt-(VTOTAL-VDISP).
- Sync:
  - hs_n is 0 while HFP ≤ hcnt < HFP+HPULSE.
  - vs_n is 0 while VFP ≤ vcnt < VFP+VPULSE, for whole lines.
- mode is latched into mode_q only in the cycle where hcnt=0 and vcnt=0. Changes mid-frame are ignored until the next frame.
- Modes:
  - GRID: white when x%GRID==0 or y%GRID==0, else black.
  - BARS: 8 vertical bars of width HDISP/8 (integer division). Colours in order: white, yellow, cyan, green, magenta, red, blue, black. Columns x ≥ 8·(HDISP/8) are black. Bars are computed with a bar-width counter, with no divider.
  - STREAM: pix_ready = (mode_q==STREAM) & active(hcnt,vcnt), combinational.
    - pix_valid&pix_ready → next video_rgb = pix_data.
    - pix_ready&!pix_valid → next video_rgb = UNDERFLOW_RGB and underflow←1. The missing pixel is skipped, not delayed.
  - BLACK: all active pixels 0.
- video_rgb is 0 whenever video_blank=0, in every mode.
- underflow clears only on reset.
- frame_start is combinational from the counters: 1 when hcnt=0 and vcnt=0.

## Timing
- All video_* outputs except video_clk are registered. They appear exactly 1 cycle after the counter state that produced them, and HS/VS/BLANK/RGB stay mutually aligned.
- video_clk = pixel_clk, combinational pass-through.
- Reset values:
  - hcnt=0, vcnt=0, mode_q=BLACK.
  - video_hs=1, video_vs=1, video_blank=0, video_rgb=0, underflow=0.
  - pix_ready=0, because mode_q=BLACK.
- Reset asserted mid-line: all of the above are forced immediately, asynchronously. After release the raster restarts at origin and frame_start pulses in the first cycle.
- Frame period is HTOTAL·VTOTAL cycles. Line period is HTOTAL cycles.
- Stream handshake:
  - Exactly HDISP·VDISP ready cycles per frame.
  - Upstream may hold pix_valid high indefinitely.
  - pix_data is sampled only when ready&valid.

## Structure
- Package video_gen_pkg holds:
  - typedef enum logic[1:0] {BLACK, GRID, BARS, STREAM} vmode_t
  - the 8 bar colour constants and WHITE/BLACK localparams
- Sub-module video_raster_cnt holds hcnt/vcnt, region decode, x/y and frame_start, parameterised identically.
- The top level adds pattern muxing, the stream handshake and the output registers.

## Test plan
Bench config for all scenarios: HDISP=160, VDISP=90, HFP=2, HPULSE=3, HBP=3, VFP=1, VPULSE=2, VBP=2, giving HTOTAL=168 and VTOTAL=95.
1. Reset then free-run:
   - HS low 3 of every 168 cycles.
   - VS low for 336 cycles per frame.
   - BLANK high 160 cycles per active line.
   - frame_start period 15960 cycles.
   - All outputs at their reset values during reset.
2. mode=GRID:
   - Pixel (0,0) = FFFFFF, (16,5) = FFFFFF, (5,5) = 000000.
   - Output matches the `screen` dump for a 160×90 grid.
3. mode=BARS:
   - x=0..19 → FFFFFF, x=20..39 → FFFF00, x=140..159 → 000000.
   - Identical for every line.
4. mode=STREAM, pix_valid always 1, pix_data = incrementing counter:
   - 14400 transfers per frame.
   - video_rgb in the first active cycle = first accepted value.
   - underflow stays 0.
5. mode=STREAM with pix_valid dropped for 1 cycle mid-line:
   - That pixel = FF00FF.
   - underflow=1 and it persists.
   - The next pixel is the next accepted pix_data.
6. mode changed GRID→BARS at line 40, then pixel_rst_n pulsed low 3 cycles at hcnt=100:
   - Pattern stays GRID until the next frame_start.
   - Reset forces outputs immediately.
   - Raster restarts at origin.

Source files
------------

// File: rtl/video_gen_pkg.sv
// Shared mode encoding and colour constants for the video pattern generator.
package video_gen_pkg;

  typedef enum logic [1:0] {
    BLACK  = 2'd0,
    GRID   = 2'd1,
    BARS   = 2'd2,
    STREAM = 2'd3
  } vmode_t;

  localparam int unsigned NUM_BARS = 8;

  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;

  // Colour bar palette, left to right.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = COL_WHITE;
      3'd1:    c = COL_YELLOW;
      3'd2:    c = COL_CYAN;
      3'd3:    c = COL_GREEN;
      3'd4:    c = COL_MAGENTA;
      3'd5:    c = COL_RED;
      3'd6:    c = COL_BLUE;
      default: c = COL_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_raster_cnt.sv
// Raster position counters with sync/active decode and active-area coordinates.
module video_raster_cnt #(
  parameter int unsigned HDISP  = 800,
  parameter int unsigned VDISP  = 480,
  parameter int unsigned HFP    = 40,
  parameter int unsigned HPULSE = 48,
  parameter int unsigned HBP    = 40,
  parameter int unsigned VFP    = 13,
  parameter int unsigned VPULSE = 3,
  parameter int unsigned VBP    = 29,
  localparam int unsigned HTOTAL = HFP + HPULSE + HBP + HDISP,
  localparam int unsigned VTOTAL = VFP + VPULSE + VBP + VDISP,
  localparam int unsigned HW     = $clog2(HTOTAL),
  localparam int unsigned VW     = $clog2(VTOTAL)
) (
  input  logic          pixel_clk,
  input  logic          pixel_rst_n,
  output logic          active_c,
  output logic          hsync_n_c,
  output logic          vsync_n_c,
  output logic          frame_start_c,
  output logic [HW-1:0] x_c,
  output logic [VW-1:0] y_c
);

  localparam int unsigned HOFF = HTOTAL - HDISP;
  localparam int unsigned VOFF = VTOTAL - VDISP;

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;

  // Pixel counter wraps each line; line counter advances on pixel wrap.
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == HW'(HTOTAL - 1)) begin
      hcnt <= '0;
      vcnt <= (vcnt == VW'(VTOTAL - 1)) ? '0 : vcnt + VW'(1);
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  // Region decode: front porch, sync, back porch, active on each axis.
  always_comb begin
    hsync_n_c     = !((hcnt >= HW'(HFP)) && (hcnt < HW'(HFP + HPULSE)));
    vsync_n_c     = !((vcnt >= VW'(VFP)) && (vcnt < VW'(VFP + VPULSE)));
    active_c      = (hcnt >= HW'(HOFF)) && (vcnt >= VW'(VOFF));
    frame_start_c = (hcnt == '0) && (vcnt == '0);
    x_c           = hcnt - HW'(HOFF);
    y_c           = vcnt - VW'(VOFF);
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Raster video source: test patterns or an upstream pixel stream onto video_if.
module video_pattern_gen #(
  parameter int unsigned HDISP         = 800,
  parameter int unsigned VDISP         = 480,
  parameter int unsigned HFP           = 40,
  parameter int unsigned HPULSE        = 48,
  parameter int unsigned HBP           = 40,
  parameter int unsigned VFP           = 13,
  parameter int unsigned VPULSE        = 3,
  parameter int unsigned VBP           = 29,
  parameter int unsigned GRID          = 16,
  parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst_n,
  input  logic [1:0]  mode,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        frame_start,
  output logic        underflow,
  output logic        video_clk,
  output logic        video_hs,
  output logic        video_vs,
  output logic        video_blank,
  output logic [23:0] video_rgb
);

  import video_gen_pkg::*;

  localparam int unsigned HTOTAL = HFP + HPULSE + HBP + HDISP;
  localparam int unsigned VTOTAL = VFP + VPULSE + VBP + VDISP;
  localparam int unsigned HW     = $clog2(HTOTAL);
  localparam int unsigned VW     = $clog2(VTOTAL);
  localparam int unsigned BARW   = HDISP / NUM_BARS;
  localparam int unsigned BCW    = (BARW > 1) ? $clog2(BARW) : 1;

  logic          active_c;
  logic          hsync_n_c;
  logic          vsync_n_c;
  logic          frame_start_c;
  logic [HW-1:0] x_c;
  logic [VW-1:0] y_c;

  vmode_t        mode_q;
  logic [BCW-1:0] bar_cnt;
  logic [3:0]    bar_idx;
  logic          grid_hit_c;
  logic [23:0]   pattern_c;

  video_raster_cnt #(
    .HDISP (HDISP),  .VDISP (VDISP),
    .HFP   (HFP),    .HPULSE(HPULSE), .HBP(HBP),
    .VFP   (VFP),    .VPULSE(VPULSE), .VBP(VBP)
  ) u_raster (
    .pixel_clk    (pixel_clk),
    .pixel_rst_n  (pixel_rst_n),
    .active_c     (active_c),
    .hsync_n_c    (hsync_n_c),
    .vsync_n_c    (vsync_n_c),
    .frame_start_c(frame_start_c),
    .x_c          (x_c),
    .y_c          (y_c)
  );

  assign video_clk   = pixel_clk;
  assign frame_start = frame_start_c;
  assign pix_ready   = (mode_q == video_gen_pkg::STREAM) && active_c;

  // Mode is only sampled at the raster origin so a frame never mixes patterns.
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      mode_q <= video_gen_pkg::BLACK;
    end else if (frame_start_c) begin
      mode_q <= vmode_t'(mode);
    end
  end

  // Bar tracker: holds bar index for the pixel at the current position;
  // index 8 and above means past the last full bar (black).
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (!active_c) begin
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (bar_cnt == BCW'(BARW - 1)) begin
      bar_cnt <= '0;
      if (!bar_idx[3]) begin
        bar_idx <= bar_idx + 4'd1;
      end
    end else begin
      bar_cnt <= bar_cnt + BCW'(1);
    end
  end

  // Pattern selection for the current active pixel.
  always_comb begin
    pattern_c  = COL_BLACK;
    grid_hit_c = ((x_c & HW'(GRID - 1)) == '0) || ((y_c & VW'(GRID - 1)) == '0);
    case (mode_q)
      video_gen_pkg::GRID:   pattern_c = grid_hit_c ? COL_WHITE : COL_BLACK;
      video_gen_pkg::BARS:   pattern_c = bar_idx[3] ? COL_BLACK : bar_colour(bar_idx[2:0]);
      video_gen_pkg::STREAM: pattern_c = pix_valid ? pix_data : UNDERFLOW_RGB;
      default:               pattern_c = COL_BLACK;
    endcase
  end

  // Output registers keep HS/VS/BLANK/RGB aligned one cycle behind the counters.
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      video_hs    <= 1'b1;
      video_vs    <= 1'b1;
      video_blank <= 1'b0;
      video_rgb   <= COL_BLACK;
      underflow   <= 1'b0;
    end else begin
      video_hs    <= hsync_n_c;
      video_vs    <= vsync_n_c;
      video_blank <= active_c;
      video_rgb   <= active_c ? pattern_c : COL_BLACK;
      if (pix_ready && !pix_valid) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen on a small 160x90 raster.
module tb_video_pattern_gen;

  localparam int unsigned HDISP = 160, VDISP = 90;
  localparam int unsigned HFP = 2, HPULSE = 3, HBP = 3;
  localparam int unsigned VFP = 1, VPULSE = 2, VBP = 2;
  localparam int HTOTAL = 168, VTOTAL = 95, HOFF = 8, VOFF = 5;
  localparam int FRAME = HTOTAL * VTOTAL;

  localparam logic [1:0] M_BLACK  = 2'd0;
  localparam logic [1:0] M_GRID   = 2'd1;
  localparam logic [1:0] M_BARS   = 2'd2;
  localparam logic [1:0] M_STREAM = 2'd3;

  logic        pixel_clk = 1'b0;
  logic        pixel_rst_n;
  logic [1:0]  mode;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready, frame_start, underflow;
  logic        video_clk, video_hs, video_vs, video_blank;
  logic [23:0] video_rgb;

  video_pattern_gen #(
    .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP), .GRID(16), .UNDERFLOW_RGB(24'hFF00FF)
  ) dut (
    .pixel_clk(pixel_clk), .pixel_rst_n(pixel_rst_n), .mode(mode),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .frame_start(frame_start), .underflow(underflow), .video_clk(video_clk),
    .video_hs(video_hs), .video_vs(video_vs), .video_blank(video_blank),
    .video_rgb(video_rgb)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    int          scen;
    int          x;
    int          y;
    logic [23:0] rgb;
  } vec_t;

  vec_t        vecs[$];
  int          errors = 0;
  int          checks = 0;

  // Reference raster model state
  int          mh, mv;
  logic [1:0]  mq;
  logic        muf;
  logic        last_xfer;
  int          cyc, last_fs, fs_period;
  int          hs_low, vs_low, blank_hi, ready_cnt, xfer_cnt;
  logic [23:0] sd;
  logic [23:0] bar_tab [0:7];
  logic [23:0] cap [0:VDISP-1][0:HDISP-1];

  function automatic logic m_act(input int h, input int v);
    return (h >= HOFF) && (v >= VOFF);
  endfunction

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    mh = 0; mv = 0; mq = M_BLACK; muf = 1'b0; last_xfer = 1'b0;
  endtask

  // One clock: predict registered outputs from the previous position, then compare.
  task automatic tick();
    logic [23:0] er;
    logic        eh, ev, eb, rdy;
    logic [29:0] got, exp;
    int          x, y;
    @(posedge pixel_clk); #1;
    cyc++;
    eh  = !((mh >= HFP) && (mh < HFP + HPULSE));
    ev  = !((mv >= VFP) && (mv < VFP + VPULSE));
    eb  = m_act(mh, mv);
    x   = mh - HOFF;
    y   = mv - VOFF;
    rdy = (mq == M_STREAM) && eb;
    er  = 24'h0;
    if (eb) begin
      case (mq)
        M_GRID:   er = ((x % 16 == 0) || (y % 16 == 0)) ? 24'hFFFFFF : 24'h000000;
        M_BARS:   er = (x / 20 < 8) ? bar_tab[x / 20] : 24'h000000;
        M_STREAM: er = pix_valid ? pix_data : 24'hFF00FF;
        default:  er = 24'h000000;
      endcase
    end
    if (rdy && !pix_valid) muf = 1'b1;
    last_xfer = rdy && pix_valid;
    if (mh == 0 && mv == 0) mq = mode;
    mh++;
    if (mh == HTOTAL) begin
      mh = 0;
      mv++;
      if (mv == VTOTAL) mv = 0;
    end
    exp = {eh, ev, eb, (mh == 0 && mv == 0), (mq == M_STREAM) && m_act(mh, mv), muf, er};
    got = {video_hs, video_vs, video_blank, frame_start, pix_ready, underflow, video_rgb};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL cycle h=%0d v=%0d {hs,vs,blank,fs,ready,uf,rgb}: got %h expected %h",
               mh, mv, got, exp);
    end
    if (!video_hs) hs_low++;
    if (!video_vs) vs_low++;
    if (video_blank) blank_hi++;
    if (frame_start) begin
      fs_period = cyc - last_fs;
      last_fs   = cyc;
    end
    if (eb) cap[y][x] = video_rgb;
  endtask

  // One full frame from the origin, optionally driving the pixel stream.
  task automatic run_frame(input logic stream, input int drop_h, input int drop_v);
    ready_cnt = 0;
    xfer_cnt  = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (stream) begin
        pix_data  = sd;
        pix_valid = !(mh == drop_h && mv == drop_v);
        if (mh == 0 && mv == drop_v) check("underflow_before_drop", 24'(underflow), 24'h0);
      end
      if (pix_ready) ready_cnt++;
      if (pix_ready && pix_valid) xfer_cnt++;
      tick();
      if (stream && last_xfer) sd = sd + 24'd1;
    end
  endtask

  task automatic check_table(input int scen);
    foreach (vecs[i]) begin
      if (vecs[i].scen == scen)
        check($sformatf("pix s%0d (%0d,%0d)", scen, vecs[i].x, vecs[i].y),
              cap[vecs[i].y][vecs[i].x], vecs[i].rgb);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hs"},    24'(video_hs),    24'h1);
    check({tag, "_vs"},    24'(video_vs),    24'h1);
    check({tag, "_blank"}, 24'(video_blank), 24'h0);
    check({tag, "_rgb"},   video_rgb,        24'h0);
    check({tag, "_ready"}, 24'(pix_ready),   24'h0);
    check({tag, "_uf"},    24'(underflow),   24'h0);
  endtask

  initial begin
    bar_tab[0] = 24'hFFFFFF; bar_tab[1] = 24'hFFFF00; bar_tab[2] = 24'h00FFFF;
    bar_tab[3] = 24'h00FF00; bar_tab[4] = 24'hFF00FF; bar_tab[5] = 24'hFF0000;
    bar_tab[6] = 24'h0000FF; bar_tab[7] = 24'h000000;

    vecs.push_back('{2,   0,  0, 24'hFFFFFF});
    vecs.push_back('{2,  16,  5, 24'hFFFFFF});
    vecs.push_back('{2,   5,  5, 24'h000000});
    vecs.push_back('{2,   5, 16, 24'hFFFFFF});
    vecs.push_back('{2, 144,  3, 24'hFFFFFF});
    vecs.push_back('{2, 159, 89, 24'h000000});
    vecs.push_back('{3,   0,  0, 24'hFFFFFF});
    vecs.push_back('{3,  19,  7, 24'hFFFFFF});
    vecs.push_back('{3,  20,  7, 24'hFFFF00});
    vecs.push_back('{3,  39,  7, 24'hFFFF00});
    vecs.push_back('{3,  40,  7, 24'h00FFFF});
    vecs.push_back('{3,  60,  7, 24'h00FF00});
    vecs.push_back('{3,  80,  7, 24'hFF00FF});
    vecs.push_back('{3, 100,  7, 24'hFF0000});
    vecs.push_back('{3, 120,  7, 24'h0000FF});
    vecs.push_back('{3, 140, 89, 24'h000000});
    vecs.push_back('{3, 159, 89, 24'h000000});
    vecs.push_back('{3,  19, 89, 24'hFFFFFF});
    vecs.push_back('{4,   0,  0, 24'h100000});
    vecs.push_back('{4,   1,  0, 24'h100001});
    vecs.push_back('{4,  49, 10, 24'h100671});
    vecs.push_back('{4,  50, 10, 24'hFF00FF});
    vecs.push_back('{4,  51, 10, 24'h100672});
    vecs.push_back('{4, 159, 89, 24'h10383E});
    vecs.push_back('{6,   5, 38, 24'h000000});
    vecs.push_back('{6,  32, 38, 24'hFFFFFF});
    vecs.push_back('{6,  33, 38, 24'h000000});
    vecs.push_back('{7,   5,  2, 24'hFFFFFF});
    vecs.push_back('{7,  25,  2, 24'hFFFF00});
    vecs.push_back('{7, 150,  4, 24'h000000});

    // Reset values and clock forwarding
    pixel_rst_n = 1'b0;
    mode = M_BLACK; pix_valid = 1'b0; pix_data = 24'h0; sd = 24'h100000;
    cyc = 0; last_fs = 0; fs_period = 0;
    hs_low = 0; vs_low = 0; blank_hi = 0;
    repeat (3) @(posedge pixel_clk);
    #1;
    check_reset_outputs("in_reset");
    check("video_clk_high", 24'(video_clk), 24'h1);
    @(negedge pixel_clk); #1;
    check("video_clk_low", 24'(video_clk), 24'h0);
    @(posedge pixel_clk); #2;
    pixel_rst_n = 1'b1;
    #1;
    check("fs_after_release", 24'(frame_start), 24'h1);
    model_reset();

    // Scenario 1: free-running BLACK frame, timing statistics
    run_frame(1'b0, -1, -1);
    check("hs_low_per_frame",    24'(hs_low),    24'(285));
    check("vs_low_per_frame",    24'(vs_low),    24'(336));
    check("blank_hi_per_frame",  24'(blank_hi),  24'(14400));
    check("frame_start_period",  24'(fs_period), 24'(FRAME));

    // Scenario 2: grid
    mode = M_GRID;
    run_frame(1'b0, -1, -1);
    check_table(2);

    // Scenario 3: colour bars
    mode = M_BARS;
    run_frame(1'b0, -1, -1);
    check_table(3);

    // Scenarios 4/5: stream, always valid except one dropped beat at (50,10)
    mode = M_STREAM;
    run_frame(1'b1, 50 + HOFF, 10 + VOFF);
    pix_valid = 1'b0;
    check("ready_cycles",  24'(ready_cnt), 24'(14400));
    check("transfers",     24'(xfer_cnt),  24'(14399));
    check("underflow_set", 24'(underflow), 24'h1);
    check_table(4);

    // Scenario 6: GRID->BARS mid-frame, then async reset mid-line
    mode = M_GRID;
    while (!(mh == 100 && mv == 45)) begin
      if (mh == 0 && mv == 40) mode = M_BARS;
      tick();
    end
    check("underflow_sticky", 24'(underflow), 24'h1);
    #2;
    pixel_rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    check_table(6);
    repeat (3) @(posedge pixel_clk);
    #2;
    pixel_rst_n = 1'b1;
    #1;
    check("fs_restart", 24'(frame_start), 24'h1);
    model_reset();
    repeat (10 * HTOTAL) tick();
    check_table(7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
